// File: rtl/cache_line_refill.sv
// rtl/cache_line_refill.sv - critical-word-first cache line refill engine
module cache_line_refill #(
    parameter int WAY_COUNT      = 2,
    parameter int SET_COUNT      = 64,
    parameter int WAY_WORD_COUNT = 4,
    localparam int WB = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1,
    localparam int SB = $clog2(SET_COUNT),
    localparam int OB = $clog2(WAY_WORD_COUNT),
    localparam int TB = 32 - OB - SB - 2
) (
    input  logic                        clk,
    input  logic                        rstn_i,
    input  logic                        start_i,
    input  logic [31:0]                 addr_i,
    input  logic [WB-1:0]               way_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        crit_valid_o,
    output logic [31:0]                 crit_rdata_o,
    output logic                        data_req_o,
    output logic [31:0]                 data_addr_o,
    input  logic                        data_gnt_i,
    input  logic                        data_rvalid_i,
    input  logic [31:0]                 data_rdata_i,
    output logic                        mem_enable_o,
    output logic                        mem_write_enable_o,
    output logic [SB-1:0]               mem_set_o,
    output logic [WB-1:0]               mem_way_o,
    output logic                        mem_line_valid_o,
    output logic [TB-1:0]               mem_line_tag_o,
    output logic [32*WAY_WORD_COUNT-1:0] mem_line_o,
    output logic [WAY_WORD_COUNT-1:0]   mem_line_ww_enable_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t state;
    state_t state_next;

    logic [SB-1:0]                 set_q;
    logic [WB-1:0]                 way_q;
    logic [TB-1:0]                 tag_q;
    logic [OB-1:0]                 word_cnt;
    logic [OB-1:0]                 rcv_cnt;
    logic [32*WAY_WORD_COUNT-1:0]  line_q;
    logic                          crit_valid_q;
    logic [31:0]                   crit_rdata_q;

    // Byte offset bits never reach the bus; words are always aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // State register; reset aborts any refill in flight.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one bus transaction at a time, line written once all words arrived.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = REQ;
            REQ:     if (data_gnt_i) state_next = WAIT;
            WAIT: begin
                if (data_rvalid_i) begin
                    state_next = (rcv_cnt == OB'(WAY_WORD_COUNT - 1)) ? WRITE : REQ;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, wrap-order word counter, line assembly and critical word.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            set_q        <= '0;
            way_q        <= '0;
            tag_q        <= '0;
            word_cnt     <= '0;
            rcv_cnt      <= '0;
            line_q       <= '0;
            crit_valid_q <= 1'b0;
            crit_rdata_q <= '0;
        end else begin
            crit_valid_q <= 1'b0;
            if (state == IDLE && start_i) begin
                set_q    <= addr_i[OB+SB+1:OB+2];
                tag_q    <= addr_i[31:OB+SB+2];
                way_q    <= way_i;
                word_cnt <= addr_i[OB+1:2];
                rcv_cnt  <= '0;
            end
            if (state == WAIT && data_rvalid_i) begin
                for (int w = 0; w < WAY_WORD_COUNT; w++) begin
                    if (word_cnt == OB'(w)) begin
                        line_q[32*w +: 32] <= data_rdata_i;
                    end
                end
                // Counter width equals the line index width, so N-1 wraps to 0.
                word_cnt <= word_cnt + 1'b1;
                rcv_cnt  <= rcv_cnt + 1'b1;
                if (rcv_cnt == '0) begin
                    crit_valid_q <= 1'b1;
                    crit_rdata_q <= data_rdata_i;
                end
            end
        end
    end

    assign busy_o               = (state != IDLE);
    assign data_req_o           = (state == REQ);
    assign data_addr_o          = {tag_q, set_q, word_cnt, 2'b00};
    assign done_o               = (state == WRITE);
    assign mem_write_enable_o   = (state == WRITE);
    assign mem_enable_o         = (state == WRITE);
    assign mem_set_o            = set_q;
    assign mem_way_o            = way_q;
    assign mem_line_tag_o       = tag_q;
    assign mem_line_valid_o     = 1'b1;
    assign mem_line_o           = line_q;
    assign mem_line_ww_enable_o = '1;
    assign crit_valid_o         = crit_valid_q;
    assign crit_rdata_o         = crit_rdata_q;

endmodule

// File: tb/tb_cache_line_refill.sv
// tb/tb_cache_line_refill.sv - randomized self-checking bench for cache_line_refill
module tb_cache_line_refill;

    localparam int N   = 4;
    localparam int SC  = 64;
    localparam int OB  = 2;
    localparam int SB  = 6;
    localparam int TBW = 22;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   addr = '0;
    logic [0:0]    way = '0;
    logic          busy, done, crit_valid;
    logic [31:0]   crit_rdata;
    logic          data_req;
    logic [31:0]   data_addr;
    logic          data_gnt = 1'b0;
    logic          data_rvalid = 1'b0;
    logic [31:0]   data_rdata = '0;
    logic          mem_en, mem_we;
    logic [SB-1:0] mem_set;
    logic [0:0]    mem_way;
    logic          mem_valid;
    logic [TBW-1:0] mem_tag;
    logic [32*N-1:0] mem_line;
    logic [N-1:0]  mem_ww;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_line_refill #(
        .WAY_COUNT(2), .SET_COUNT(SC), .WAY_WORD_COUNT(N)
    ) dut (
        .clk(clk), .rstn_i(rstn), .start_i(start), .addr_i(addr), .way_i(way),
        .busy_o(busy), .done_o(done), .crit_valid_o(crit_valid), .crit_rdata_o(crit_rdata),
        .data_req_o(data_req), .data_addr_o(data_addr), .data_gnt_i(data_gnt),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .mem_enable_o(mem_en), .mem_write_enable_o(mem_we), .mem_set_o(mem_set),
        .mem_way_o(mem_way), .mem_line_valid_o(mem_valid), .mem_line_tag_o(mem_tag),
        .mem_line_o(mem_line), .mem_line_ww_enable_o(mem_ww)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One refill driven from the current falling edge; the bus responder and the
    // expected line are derived from the address arithmetic of the line layout.
    task automatic do_refill(input logic [31:0] a, input int w, input int gd, input int rd,
                             input bit inject, input bit seq, input int abort_at);
        int          ws;
        logic [31:0] base, exp_addr, d, first;
        logic [31:0] exp_w [N];
        ws   = int'((a >> 2) % N);
        base = a & ~32'(N * 4 - 1);
        first = '0;
        for (int j = 0; j < N; j++) exp_w[j] = '0;
        start = 1'b1; addr = a; way = 1'(w);
        @(negedge clk);
        start = 1'b0; addr = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) begin
            exp_addr = base | 32'(((ws + i) % N) * 4);
            for (int k = 0; k <= gd; k++) begin
                if (k > 0) @(negedge clk);
                check("req_held", 64'(data_req), 64'd1);
                check("req_addr", 64'(data_addr), 64'(exp_addr));
                data_gnt = (k == gd);
            end
            @(negedge clk);
            data_gnt = 1'b0;
            check("req_drop_after_gnt", 64'(data_req), 64'd0);
            if (inject) begin start = 1'b1; addr = $urandom; end
            repeat (rd) begin
                @(negedge clk);
                check("one_outstanding", 64'(data_req), 64'd0);
            end
            d = seq ? 32'hA0 + 32'(i) : $urandom;
            if (i == 0) first = d;
            exp_w[(ws + i) % N] = d;
            data_rvalid = 1'b1; data_rdata = d; start = 1'b0;
            @(negedge clk);
            data_rvalid = 1'b0;
            check("crit_valid", 64'(crit_valid), (i == 0) ? 64'd1 : 64'd0);
            check("crit_rdata", 64'(crit_rdata), 64'(first));
            if (i + 1 == abort_at) begin
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_req", 64'(data_req), 64'd0);
                check("abort_line", 64'(mem_line[63:0]), 64'd0);
                check("abort_crit", 64'(crit_rdata), 64'd0);
                data_rvalid = 1'b1; data_rdata = $urandom;
                @(negedge clk);
                data_rvalid = 1'b0;
                check("late_rvalid_busy", 64'(busy), 64'd0);
                check("late_rvalid_crit", 64'(crit_valid), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_write", 64'(mem_we), 64'd0);
                end
                return;
            end
            if (i < N - 1) check("no_early_write", 64'(mem_we), 64'd0);
        end
        check("write_done", 64'(done), 64'd1);
        check("write_we", 64'(mem_we), 64'd1);
        check("write_en", 64'(mem_en), 64'd1);
        check("write_busy", 64'(busy), 64'd1);
        check("write_set", 64'(mem_set), 64'((a >> (OB + 2)) % SC));
        check("write_way", 64'(mem_way), 64'(w));
        check("write_tag", 64'(mem_tag), 64'(a >> (OB + SB + 2)));
        check("write_valid", 64'(mem_valid), 64'd1);
        check("write_ww", 64'(mem_ww), 64'hF);
        for (int j = 0; j < N; j++) check($sformatf("line_w%0d", j), 64'(mem_line[32*j +: 32]), 64'(exp_w[j]));
        if (inject) begin start = 1'b1; addr = $urandom; end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        if (inject) begin
            @(negedge clk);
            check("start_in_write_ignored", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req", 64'(data_req), 64'd0);
        check("rst_addr", 64'(data_addr), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_crit", 64'(crit_valid), 64'd0);
        check("rst_line", 64'(mem_line[63:0]), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        data_rvalid = 1'b1; data_rdata = 32'hDEAD;
        @(negedge clk);
        data_rvalid = 1'b0;
        check("idle_rvalid_ignored", 64'(busy), 64'd0);

        do_refill(32'h0000_1238, 1, 0, 0, 1'b0, 1'b1, 0);
        do_refill(32'h0000_1238, 1, 3, 5, 1'b0, 1'b0, 0);
        do_refill(32'h0000_5A74, 0, 1, 2, 1'b1, 1'b0, 0);
        do_refill(32'h0000_1238, 1, 0, 1, 1'b0, 1'b0, 2);
        do_refill(32'h0000_1238, 0, 0, 0, 1'b0, 1'b1, 0);
        do_refill(32'h0000_0400, 1, 0, 0, 1'b0, 1'b1, 0);
        for (int r = 0; r < 20; r++) begin
            do_refill($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
